// File: rtl/stack_ctrl.sv
// stack_ctrl: hardware stack sequencer for PUSH/POP/CALL/RET over a 16-bit memory port
//   clk, rst_b (async, active-high) | start, op, data_in, pc_in, target: request
//   sp_val: external stack pointer; sp_inc/sp_dec: one-cycle step pulses
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack: held-request memory handshake
//   busy, done, err, data_out, pc_ld, pc_out: status and results
module stack_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] data_in,
  input  logic [15:0] pc_in,
  input  logic [15:0] target,
  input  logic [15:0] sp_val,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] data_out,
  output logic        pc_ld,
  output logic [15:0] pc_out
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [2:0] {IDLE, DEC, WR, RD, INC, FIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [15:0]   tgt_q;
  logic          err_q;
  logic          bad;
  // op[0] set means a pop-type operation (POP/RET), clear means push-type (PUSH/CALL)
  assign bad = op[0] ? cnt == '0 : cnt == CW'(DEPTH);
  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !start ? IDLE : bad ? FIN : op[0] ? RD : DEC;
      DEC:  nxt = WR;
      WR:   nxt = mem_ack ? FIN : WR;
      RD:   nxt = mem_ack ? INC : RD;
      INC:  nxt = FIN;
      default: nxt = IDLE;
    endcase
    busy    = state != IDLE;
    sp_dec  = state == DEC;
    sp_inc  = state == INC;
    mem_req = state == WR || state == RD;
    mem_we  = state == WR;
    done    = state == FIN;
    err     = done & err_q;
    pc_ld   = done & ~err_q & op_q[1];
    pc_out  = !pc_ld ? '0 : op_q[0] ? data_out : tgt_q;
  end
  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) begin
      cnt       <= '0;
      op_q      <= '0;
      tgt_q     <= '0;
      err_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      data_out  <= '0;
    end else begin
      // the push address is the pre-decrement pointer minus one; pops read at the pointer itself
      if (state == IDLE && start) begin
        op_q      <= op;
        tgt_q     <= target;
        err_q     <= bad;
        mem_addr  <= op[0] ? sp_val : sp_val - 16'd1;
        mem_wdata <= op[1] ? pc_in : data_in;
      end
      if (state == RD && mem_ack) data_out <= mem_rdata;
      if (state == FIN && !err_q) cnt <= op_q[0] ? cnt - 1'b1 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: randomized self-checking bench for stack_ctrl against a queue-based stack model
module tb_stack_ctrl;
  logic        clk = 0, rst_b = 1, start = 0, mem_ack = 0;
  logic [1:0]  op = 0;
  logic [15:0] data_in = 0, pc_in = 0, target = 0, sp_val = 0, mem_rdata;
  logic        sp_inc, sp_dec, mem_req, mem_we, busy, done, err, pc_ld;
  logic [15:0] mem_addr, mem_wdata, data_out, pc_out;
  int          n_vec = 0, n_err = 0, wait_cfg = 0, wcnt = 0;
  bit          ack_hold = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] stk [$];
  logic [15:0] last_pop = 0;

  stack_ctrl #(.DEPTH(256)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .data_in(data_in), .pc_in(pc_in),
    .target(target), .sp_val(sp_val), .sp_inc(sp_inc), .sp_dec(sp_dec), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err), .data_out(data_out),
    .pc_ld(pc_ld), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
    if (sp_inc) sp_val <= sp_val + 16'd1;
    else if (sp_dec) sp_val <= sp_val - 16'd1;
  end

  // memory responder: ack after wait_cfg stall cycles, random noise acks while idle
  always @(negedge clk)
    if (!mem_req) begin
      wcnt = 0;
      mem_ack = $urandom_range(0, 3) == 0;
    end else begin
      mem_ack = !ack_hold && wcnt == wait_cfg;
      wcnt++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [15:0] d, input logic [15:0] pc,
                       input logic [15:0] tg, input int w, input bit ghost);
    bit          bad = o[0] ? stk.size() == 0 : stk.size() == 256;
    logic [15:0] sp0 = sp_val;
    logic [15:0] exp_addr = o[0] ? sp0 : sp0 - 16'd1;
    logic [15:0] exp_wd = o[1] ? pc : d;
    logic [15:0] exp_sp = bad ? sp0 : o[0] ? sp0 + 16'd1 : sp0 - 16'd1;
    logic [15:0] top = stk.size() > 0 ? stk[stk.size() - 1] : 16'h0;
    logic [15:0] got_pc = 0, got_do = 0;
    bit          got_err = 0, got_ld = 0;
    int          k = 0, nreq = 0, ninc = 0, ndec = 0, proto = 0;
    wait_cfg = w;
    op = o; data_in = d; pc_in = pc; target = tg; start = 1;
    do begin
      @(negedge clk);
      k++;
      start = 0;
      if (mem_req) nreq++;
      if (sp_inc) ninc++;
      if (sp_dec) ndec++;
      if (sp_inc && sp_dec) proto++;
      if (busy !== 1'b1) proto++;
      if (mem_req && (mem_addr !== exp_addr || mem_we !== !o[0])) proto++;
      if (mem_req && mem_we && mem_wdata !== exp_wd) proto++;
      if (!done && (pc_out !== 16'h0 || err !== 1'b0 || pc_ld !== 1'b0)) proto++;
      if (done) begin
        got_err = err; got_ld = pc_ld; got_pc = pc_out; got_do = data_out;
      end else if (ghost) begin
        start = 1; op = 2'($urandom); data_in = 16'($urandom);
        pc_in = 16'($urandom); target = 16'($urandom);
      end
    end while (!done && k < 50);
    start = 0;
    if (!bad) begin
      if (o[0]) begin
        last_pop = stk.pop_back();
      end else stk.push_back(exp_wd);
    end
    chk("latency", k, bad ? 1 : 3 + w);
    chk("err", got_err, bad);
    chk("pc_ld", got_ld, !bad && o[1]);
    chk("pc_out", got_pc, (!bad && o[1]) ? (o[0] ? top : tg) : 16'h0);
    chk("data_out", got_do, last_pop);
    chk("mem_req_cycles", nreq, bad ? 0 : w + 1);
    chk("sp_dec_count", ndec, (!bad && !o[0]) ? 1 : 0);
    chk("sp_inc_count", ninc, (!bad && o[0]) ? 1 : 0);
    chk("protocol", proto, 0);
    chk("sp_val", sp_val, exp_sp);
    if (!bad && !o[0]) chk("mem_write", mem[exp_addr], exp_wd);
    @(negedge clk);
    chk("idle_after", {busy, done, mem_req}, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bits", {busy, done, err, pc_ld, sp_inc, sp_dec, mem_req, mem_we}, 0);
    chk("rst_words", {data_out, pc_out}, 0);
    chk("rst_mem", {mem_addr, mem_wdata}, 0);
    rst_b = 0;
    do_op(2'b00, 16'hBEEF, 16'h0, 16'h0, 0, 0);
    chk("push_addr", mem[16'hFFFF], 16'hBEEF);
    do_op(2'b01, 16'h0, 16'h0, 16'h0, 3, 0);
    chk("pop_val", data_out, 16'hBEEF);
    do_op(2'b01, 16'h0, 16'h0, 16'h0, 0, 0);
    do_op(2'b10, 16'h5555, 16'h0123, 16'h0400, 0, 0);
    do_op(2'b11, 16'h0, 16'h0, 16'h0, 1, 1);
    for (int i = 0; i < 300; i++)
      do_op(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, 1'($urandom));
    while (stk.size() < 256) do_op(2'b00, 16'($urandom), 16'h0, 16'h0, 0, 0);
    do_op(2'b00, 16'h1111, 16'h0, 16'h0, 0, 0);
    do_op(2'b10, 16'h0, 16'h2222, 16'h3333, 0, 1);
    do_op(2'b01, 16'h0, 16'h0, 16'h0, 0, 0);
    wait_cfg = 0; ack_hold = 1;
    op = 2'b00; data_in = 16'h1234; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("in_wr", {mem_req, mem_we, busy}, 3'b111);
    #2 rst_b = 1;
    #1 chk("rst_async", {mem_req, busy, sp_inc, sp_dec, done}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_quiet", {mem_req, busy, sp_inc, sp_dec, done, pc_ld}, 0);
    end
    rst_b = 0; ack_hold = 0;
    stk.delete(); last_pop = 0;
    chk("rst_data_out", data_out, 16'h0);
    do_op(2'b01, 16'h0, 16'h0, 16'h0, 0, 0);
    do_op(2'b00, 16'hCAFE, 16'h0, 16'h0, 2, 0);
    do_op(2'b01, 16'h0, 16'h0, 16'h0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
